alu_ctrl_mdu: RTL

- Next-generation ALU control for the multi-cycle MIPS core.
- Widens the ALU-op encoding to 3 bits, decodes the full R-type arithmetic, logic and shift set, and registers the control word.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, busy/done/stall handshake, sized by WIDTH.
- Sits between the main controller (aluop, dec_en) and the datapath ALU/register file.

---
 rtl/alu_ctrl_mdu_if.sv | 29 ++
 rtl/alu_ctrl_mdu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mdu_if.sv
// Bus between the main controller and alu_ctrl_mdu: decode request in,
// ALU control word and MDU status/results out.
interface alu_ctrl_mdu_if #(
  parameter int WIDTH = 32
);
  logic             dec_en;
  logic [2:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             illegal;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output dec_en, aluop, funct, srca, srcb,
    input  alucontrol, illegal, stall, busy, done, hi, lo, divzero
  );

  modport slave (
    input  dec_en, aluop, funct, srca, srcb,
    output alucontrol, illegal, stall, busy, done, hi, lo, divzero
  );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with registered control word and an optional iterative
// multiply/divide unit with HI/LO; the MDU is built only when ALU_MDU_EN is defined.
module alu_ctrl_mdu #(
  parameter int         WIDTH        = 32,
  parameter logic [3:0] ILLEGAL_CTRL = 4'b0010
) (
  input logic         clk,
  input logic         rst_n,
  alu_ctrl_mdu_if.slave bus
);
  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011,
                         C_NOR = 4'b0100, C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLL = 4'b1000,
                         C_SRL = 4'b1001, C_SRA = 4'b1010, C_SLTU = 4'b1011;
`ifdef ALU_MDU_EN
  localparam logic MDU_ON = 1'b1;
`else
  localparam logic MDU_ON = 1'b0;
`endif

  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic [3:0] alucontrol_q, alucontrol_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    dec_ctrl = ILLEGAL_CTRL;
    dec_ill  = 1'b0;
    case (bus.aluop)
      3'b000:  dec_ctrl = C_ADD;
      3'b001:  dec_ctrl = C_SUB;
      3'b011:  dec_ctrl = C_OR;
      3'b100:  dec_ctrl = C_AND;
      3'b101:  dec_ctrl = C_SLT;
      3'b110:  dec_ctrl = C_XOR;
      3'b111:  dec_ctrl = C_SLTU;
      default: begin
        case (bus.funct)
          6'b100000, 6'b100001: dec_ctrl = C_ADD;
          6'b100010, 6'b100011: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100110: dec_ctrl = C_XOR;
          6'b100111: dec_ctrl = C_NOR;
          6'b101010: dec_ctrl = C_SLT;
          6'b101011: dec_ctrl = C_SLTU;
          6'b000000: dec_ctrl = C_SLL;
          6'b000010: dec_ctrl = C_SRL;
          6'b000011: dec_ctrl = C_SRA;
          // HI/LO traffic is legal only when the MDU exists
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010001, 6'b010010, 6'b010011: dec_ill = ~MDU_ON;
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    alucontrol_d = alucontrol_q;
    illegal_d    = illegal_q;
    if (bus.dec_en) begin
      alucontrol_d = dec_ctrl;
      illegal_d    = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alucontrol_q <= 4'b0000;
      illegal_q    <= 1'b0;
    end else begin
      alucontrol_q <= alucontrol_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.alucontrol = alucontrol_q;
  assign bus.illegal    = illegal_q;

`ifdef ALU_MDU_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;
  logic             is_div_q, is_div_d, zero_q, zero_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;

  logic             rtype, is_mdu, is_mthi, is_mtlo, accept, sgn, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b, acc_m, mq_m, acc_v, mq_v;
  logic [WIDTH:0]   sum, r_sh, diff;
  logic [2*WIDTH-1:0] prod;

  assign rtype   = bus.dec_en && (bus.aluop == 3'b010);
  assign is_mdu  = rtype && (bus.funct[5:2] == 4'b0110);
  assign is_mthi = rtype && (bus.funct == 6'b010001);
  assign is_mtlo = rtype && (bus.funct == 6'b010011);
  assign accept  = is_mdu && !busy_q;
  assign sgn     = ~bus.funct[0];
  assign sa      = sgn & bus.srca[WIDTH-1];
  assign sb      = sgn & bus.srcb[WIDTH-1];
  assign abs_a   = sa ? -bus.srca : bus.srca;
  assign abs_b   = sb ? -bus.srcb : bus.srcb;

  // Shift-add multiply step on {acc, mq}; restoring divide step with mq as quotient.
  always_comb begin
    sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : '0);
    acc_m = sum[WIDTH:1];
    mq_m  = {sum[0], mq_q[WIDTH-1:1]};
    r_sh  = {acc_q, mq_q[WIDTH-1]};
    diff  = r_sh - {1'b0, m_q};
    if (!diff[WIDTH]) begin
      acc_v = diff[WIDTH-1:0];
      mq_v  = {mq_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_v = r_sh[WIDTH-1:0];
      mq_v  = {mq_q[WIDTH-2:0], 1'b0};
    end
    prod = neg_q_q ? -{acc_m, mq_m} : {acc_m, mq_m};
  end

  always_comb begin
    busy_d = busy_q; done_d = 1'b0; divzero_d = divzero_q; cnt_d = cnt_q;
    is_div_d = is_div_q; zero_d = zero_q; neg_q_d = neg_q_q; neg_r_d = neg_r_q;
    acc_d = acc_q; mq_d = mq_q; m_d = m_q; hi_d = hi_q; lo_d = lo_q;
    if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      acc_d = is_div_q ? acc_v : acc_m;
      mq_d  = is_div_q ? mq_v  : mq_m;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (zero_q) begin
          hi_d = mq_q;
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = neg_q_q ? -mq_v  : mq_v;
          hi_d = neg_r_q ? -acc_v : acc_v;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
    end
    if (accept) begin
      busy_d    = 1'b1;
      is_div_d  = bus.funct[1];
      zero_d    = bus.funct[1] && (bus.srcb == '0);
      divzero_d = zero_d;
      neg_q_d   = sa ^ sb;
      neg_r_d   = sa;
      acc_d     = '0;
      mq_d      = zero_d ? bus.srca : abs_a;
      m_d       = abs_b;
      cnt_d     = zero_d ? CW'(1) : CW'(WIDTH);
    end else if (!busy_q) begin
      if (is_mthi) hi_d = bus.srca;
      if (is_mtlo) lo_d = bus.srca;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0; done_q <= 1'b0; divzero_q <= 1'b0; cnt_q <= '0;
      is_div_q <= 1'b0; zero_q <= 1'b0; neg_q_q <= 1'b0; neg_r_q <= 1'b0;
      acc_q <= '0; mq_q <= '0; m_q <= '0; hi_q <= '0; lo_q <= '0;
    end else begin
      busy_q <= busy_d; done_q <= done_d; divzero_q <= divzero_d; cnt_q <= cnt_d;
      is_div_q <= is_div_d; zero_q <= zero_d; neg_q_q <= neg_q_d; neg_r_q <= neg_r_d;
      acc_q <= acc_d; mq_q <= mq_d; m_q <= m_d; hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  assign bus.stall   = (is_mdu || is_mthi || is_mtlo) && busy_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.divzero = divzero_q;
`else
  logic unused_operands;
  assign unused_operands = ^{bus.srca, bus.srcb};

  assign bus.stall   = 1'b0;
  assign bus.busy    = 1'b0;
  assign bus.done    = 1'b0;
  assign bus.hi      = '0;
  assign bus.lo      = '0;
  assign bus.divzero = 1'b0;
`endif
endmodule
